// File: rtl/bolt_slot_arbiter.sv
// Shared bolt slot pool: grants slots to the player fire key and the invader fire source.
// Define BOLT_STATS_EN to add saturating player/invader shot and drop counters.
module bolt_slot_arbiter #(
    parameter int BOLT_MAX = 4,
    parameter int PLR_MAX  = 2,
    parameter int PLR_COOL = 8
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                srtFrm,
    input  logic                enable,
    input  logic                plrKey,
    input  logic [10:0]         plrX,
    input  logic [10:0]         plrY,
    input  logic                invReq,
    input  logic [10:0]         invX,
    input  logic [10:0]         invY,
    input  logic [BOLT_MAX-1:0] retire,
    output logic [BOLT_MAX-1:0] slotBusy,
    output logic [BOLT_MAX-1:0] slotInv,
    output logic                launch,
    output logic [2:0]          launchIdx,
    output logic [10:0]         launchX,
    output logic [10:0]         launchY,
`ifdef BOLT_STATS_EN
    output logic [15:0]         plrShots,
    output logic [15:0]         invShots,
    output logic [15:0]         drops,
`endif
    output logic                invDrop
);

    localparam int CW = $clog2(PLR_COOL + 2);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LAUNCH} state_t;

    state_t              r_state, w_next;
    logic [BOLT_MAX-1:0] r_slotBusy, r_slotInv, w_setMask;
    logic                r_keyPrev, r_plrPend, r_invPend, r_rrInv, r_launchInv, r_invDrop;
    logic [CW-1:0]       r_cool;
    logic [2:0]          r_launchIdx, w_freeIdx;
    logic [10:0]         r_plrX, r_plrY, r_invX, r_invY, r_launchX, r_launchY;
    logic                w_anyFree, w_keyEdge, w_plrRoom, w_plrSet;
    logic                w_selInv, w_grantVld, w_grant;

    function automatic int popcount(input logic [BOLT_MAX-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < BOLT_MAX; i++) n += int'(v[i]);
        return n;
    endfunction

    // Lowest-index free slot, taken from the registered busy map so same-cycle retires are not seen yet
    always_comb begin
        w_anyFree = 1'b0;
        w_freeIdx = '0;
        for (int i = BOLT_MAX - 1; i >= 0; i--) begin
            if (!r_slotBusy[i]) begin
                w_anyFree = 1'b1;
                w_freeIdx = 3'(i);
            end
        end
    end

    assign w_grantVld = r_plrPend | r_invPend;
    assign w_grant    = (r_state == S_GRANT) && w_grantVld;
    assign w_selInv   = r_invPend & (~r_plrPend | r_rrInv);
    assign w_setMask  = w_grant ? (BOLT_MAX'(1) << w_freeIdx) : '0;
    assign w_keyEdge  = plrKey & ~r_keyPrev;
    assign w_plrRoom  = popcount(r_slotBusy & ~r_slotInv) < PLR_MAX;
    // A player grant in flight blocks a second edge until the cooldown is loaded
    assign w_plrSet   = w_keyEdge && (r_cool == '0) && w_plrRoom && enable
                        && !(w_grant && !w_selInv);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        launch = 1'b0;
        case (r_state)
            S_IDLE:   if (enable && w_grantVld && w_anyFree) w_next = S_GRANT;
            S_GRANT:  w_next = w_grantVld ? S_LAUNCH : S_IDLE;
            S_LAUNCH: begin
                launch = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Origin coordinates are pure data and carry no reset
    always_ff @(posedge clk) begin
        if (w_plrSet) begin
            r_plrX <= plrX;
            r_plrY <= plrY;
        end
        if (invReq) begin
            r_invX <= invX;
            r_invY <= invY;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_slotBusy  <= '0;
            r_slotInv   <= '0;
            r_keyPrev   <= 1'b0;
            r_plrPend   <= 1'b0;
            r_invPend   <= 1'b0;
            r_rrInv     <= 1'b0;
            r_launchInv <= 1'b0;
            r_invDrop   <= 1'b0;
            r_cool      <= '0;
            r_launchIdx <= '0;
            r_launchX   <= '0;
            r_launchY   <= '0;
        end else begin
            r_keyPrev  <= plrKey;
            r_invDrop  <= 1'b0;
            r_slotBusy <= (r_slotBusy | w_setMask) & ~retire;
            r_slotInv  <= ((r_slotInv & ~w_setMask) | (w_selInv ? w_setMask : '0)) & ~retire;

            if (srtFrm && r_cool != '0) r_cool <= r_cool - CW'(1);

            if (w_grant) begin
                r_launchIdx <= w_freeIdx;
                r_launchInv <= w_selInv;
                r_launchX   <= w_selInv ? r_invX : r_plrX;
                r_launchY   <= w_selInv ? r_invY : r_plrY;
                r_rrInv     <= ~w_selInv;
                if (w_selInv) begin
                    r_invPend <= 1'b0;
                end else begin
                    r_plrPend <= 1'b0;
                    r_cool    <= CW'(PLR_COOL);
                end
            end

            if (srtFrm && r_invPend && !w_anyFree) begin
                r_invPend <= 1'b0;
                r_invDrop <= 1'b1;
            end

            if (w_plrSet) r_plrPend <= 1'b1;
            if (invReq)   r_invPend <= 1'b1;

            if (!enable) begin
                r_plrPend <= 1'b0;
                r_invPend <= 1'b0;
            end
        end
    end

    assign slotBusy  = r_slotBusy;
    assign slotInv   = r_slotInv;
    assign launchIdx = r_launchIdx;
    assign launchX   = r_launchX;
    assign launchY   = r_launchY;
    assign invDrop   = r_invDrop;

`ifdef BOLT_STATS_EN
    logic [15:0] r_plrShots, r_invShots, r_drops;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_plrShots <= '0;
            r_invShots <= '0;
            r_drops    <= '0;
        end else begin
            if (launch && !r_launchInv) r_plrShots <= sat_inc(r_plrShots);
            if (launch && r_launchInv)  r_invShots <= sat_inc(r_invShots);
            if (r_invDrop)              r_drops    <= sat_inc(r_drops);
        end
    end

    assign plrShots = r_plrShots;
    assign invShots = r_invShots;
    assign drops    = r_drops;
`endif

endmodule
